sprite_compositor: RTL and testbench

//  Parametrised multi-layer sprite compositor for the VGA pixel path of the game top.
//  - Per pixel: generates ROM addresses for NUM_LAYERS sprites, applies colour-key

---
 rtl/sprite_compositor.sv | 190 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Multi-layer sprite compositor for the VGA pixel path: frame-shadowed sprite
// parameters, sprite ROM addressing, colour-key/priority merge and player collisions.
module sprite_compositor #(
  parameter int                NUM_LAYERS = 4,
  parameter int                COL_W      = 10,
  parameter int                ROW_W      = 9,
  parameter int                PIX_W      = 12,
  parameter int                ADDR_W     = 16,
  parameter int                ROM_LAT    = 1,
  parameter logic [PIX_W-1:0]  KEY_COLOR  = 12'hFFF
) (
  input  logic                         clk_25MHz,
  input  logic                         rst_n,
  input  logic                         pix_valid,
  input  logic [ROW_W-1:0]             row,
  input  logic [COL_W-1:0]             col,
  input  logic                         frame_start,
  input  logic [PIX_W-1:0]             bg_data,
  input  logic [NUM_LAYERS-1:0]        layer_en,
  input  logic [NUM_LAYERS*COL_W-1:0]  layer_x,
  input  logic [NUM_LAYERS*ROW_W-1:0]  layer_y,
  input  logic [NUM_LAYERS*COL_W-1:0]  layer_w,
  input  logic [NUM_LAYERS*ROW_W-1:0]  layer_h,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_base,
  output logic [NUM_LAYERS*ADDR_W-1:0] rom_addr,
  input  logic [NUM_LAYERS*PIX_W-1:0]  rom_data,
  output logic [PIX_W-1:0]             pix_out,
  output logic                         pix_out_vld,
  output logic [NUM_LAYERS-1:0]        collision
);

  localparam int PROD_W = ROW_W + COL_W;

  logic [NUM_LAYERS-1:0]        r_en;
  logic [COL_W-1:0]             r_x    [NUM_LAYERS];
  logic [ROW_W-1:0]             r_y    [NUM_LAYERS];
  logic [COL_W-1:0]             r_w    [NUM_LAYERS];
  logic [ROW_W-1:0]             r_h    [NUM_LAYERS];
  logic [ADDR_W-1:0]            r_base [NUM_LAYERS];

  logic [NUM_LAYERS-1:0]        w_en;
  logic [COL_W-1:0]             w_x     [NUM_LAYERS];
  logic [ROW_W-1:0]             w_y     [NUM_LAYERS];
  logic [COL_W-1:0]             w_w     [NUM_LAYERS];
  logic [ROW_W-1:0]             w_h     [NUM_LAYERS];
  logic [ADDR_W-1:0]            w_base  [NUM_LAYERS];
  logic [COL_W-1:0]             w_rel_x [NUM_LAYERS];
  logic [ROW_W-1:0]             w_rel_y [NUM_LAYERS];
  logic [PROD_W-1:0]            w_prod  [NUM_LAYERS];
  logic [ADDR_W-1:0]            w_addr  [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]        w_hit;

  logic [NUM_LAYERS*ADDR_W-1:0] r_rom_addr;
  logic [NUM_LAYERS-1:0]        r_hit_d [ROM_LAT+1];
  logic [ROM_LAT:0]             r_vld_d;
  logic [PIX_W-1:0]             r_bg_d  [ROM_LAT+1];

  logic [NUM_LAYERS-1:0]        w_opaque;
  logic [NUM_LAYERS-1:0]        w_coll;
  logic [PIX_W-1:0]             w_pix;

  logic [PIX_W-1:0]             r_pix_out;
  logic                         r_pix_vld;
  logic [NUM_LAYERS-1:0]        r_live;
  logic [NUM_LAYERS-1:0]        r_collision;

  // Sprite parameters are captured once per frame so a frame never tears
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= {NUM_LAYERS{1'b0}};
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_x[i]    <= {COL_W{1'b0}};
        r_y[i]    <= {ROW_W{1'b0}};
        r_w[i]    <= {COL_W{1'b0}};
        r_h[i]    <= {ROW_W{1'b0}};
        r_base[i] <= {ADDR_W{1'b0}};
      end
    end else if (frame_start) begin
      r_en <= layer_en;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_x[i]    <= layer_x[i*COL_W +: COL_W];
        r_y[i]    <= layer_y[i*ROW_W +: ROW_W];
        r_w[i]    <= layer_w[i*COL_W +: COL_W];
        r_h[i]    <= layer_h[i*ROW_W +: ROW_W];
        r_base[i] <= layer_base[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // The first pixel of a frame bypasses the shadow and sees the new parameters
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (frame_start) begin
        w_en[i]   = layer_en[i];
        w_x[i]    = layer_x[i*COL_W +: COL_W];
        w_y[i]    = layer_y[i*ROW_W +: ROW_W];
        w_w[i]    = layer_w[i*COL_W +: COL_W];
        w_h[i]    = layer_h[i*ROW_W +: ROW_W];
        w_base[i] = layer_base[i*ADDR_W +: ADDR_W];
      end else begin
        w_en[i]   = r_en[i];
        w_x[i]    = r_x[i];
        w_y[i]    = r_y[i];
        w_w[i]    = r_w[i];
        w_h[i]    = r_h[i];
        w_base[i] = r_base[i];
      end
    end
  end

  // Modular subtraction puts pixels left of / above a sprite far outside its box
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_rel_x[i] = col - w_x[i];
      w_rel_y[i] = row - w_y[i];
      w_hit[i]   = w_en[i] & pix_valid & (w_rel_x[i] < w_w[i]) & (w_rel_y[i] < w_h[i]);
      w_prod[i]  = PROD_W'(w_rel_y[i]) * PROD_W'(w_w[i]);
      w_addr[i]  = w_base[i] + ADDR_W'(w_prod[i]) + ADDR_W'(w_rel_x[i]);
    end
  end

  // Stage A registers plus the delay line that waits out the ROM latency
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= {(NUM_LAYERS*ADDR_W){1'b0}};
      r_vld_d    <= {(ROM_LAT+1){1'b0}};
      for (int k = 0; k <= ROM_LAT; k++) begin
        r_hit_d[k] <= {NUM_LAYERS{1'b0}};
        r_bg_d[k]  <= {PIX_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_rom_addr[i*ADDR_W +: ADDR_W] <= w_hit[i] ? w_addr[i] : {ADDR_W{1'b0}};
      end
      r_hit_d[0] <= w_hit;
      r_vld_d[0] <= pix_valid;
      r_bg_d[0]  <= bg_data;
      for (int k = 1; k <= ROM_LAT; k++) begin
        r_hit_d[k] <= r_hit_d[k-1];
        r_vld_d[k] <= r_vld_d[k-1];
        r_bg_d[k]  <= r_bg_d[k-1];
      end
    end
  end

  // Walk from lowest to highest priority so layer 0 ends up on top
  always_comb begin
    w_pix    = r_bg_d[ROM_LAT];
    w_opaque = {NUM_LAYERS{1'b0}};
    w_coll   = {NUM_LAYERS{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_opaque[i] = r_hit_d[ROM_LAT][i] & (rom_data[i*PIX_W +: PIX_W] != KEY_COLOR);
    end
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_opaque[i]) begin
        w_pix = rom_data[i*PIX_W +: PIX_W];
      end else begin
        w_pix = w_pix;
      end
    end
    for (int i = 1; i < NUM_LAYERS; i++) begin
      w_coll[i] = w_opaque[0] & w_opaque[i];
    end
  end

  // Stage B output and collision bookkeeping; the frame_start-cycle hit closes the old frame
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_out   <= {PIX_W{1'b0}};
      r_pix_vld   <= 1'b0;
      r_live      <= {NUM_LAYERS{1'b0}};
      r_collision <= {NUM_LAYERS{1'b0}};
    end else begin
      r_pix_vld <= r_vld_d[ROM_LAT];
      r_pix_out <= r_vld_d[ROM_LAT] ? w_pix : {PIX_W{1'b0}};
      if (frame_start) begin
        r_collision <= r_live | w_coll;
        r_live      <= {NUM_LAYERS{1'b0}};
      end else begin
        r_live      <= r_live | w_coll;
      end
    end
  end

  assign rom_addr    = r_rom_addr;
  assign pix_out     = r_pix_out;
  assign pix_out_vld = r_pix_vld;
  assign collision   = r_collision;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus randomized frames, all
// checked against a pixel-level reference model with a behavioural sprite ROM.
module tb_sprite_compositor;
  localparam int NL = 4;
  localparam int CW = 10;
  localparam int RW = 9;
  localparam int PW = 12;
  localparam int AW = 16;
  localparam int HN = 8192;

  logic               clk_25MHz = 1'b0;
  logic               rst_n;
  logic               pix_valid;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic               frame_start;
  logic [PW-1:0]      bg_data;
  logic [NL-1:0]      layer_en;
  logic [NL*CW-1:0]   layer_x;
  logic [NL*RW-1:0]   layer_y;
  logic [NL*CW-1:0]   layer_w;
  logic [NL*RW-1:0]   layer_h;
  logic [NL*AW-1:0]   layer_base;
  logic [NL*AW-1:0]   rom_addr;
  logic [NL*PW-1:0]   rom_data;
  logic [PW-1:0]      pix_out;
  logic               pix_out_vld;
  logic [NL-1:0]      collision;

  sprite_compositor dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .pix_valid(pix_valid), .row(row), .col(col),
    .frame_start(frame_start), .bg_data(bg_data), .layer_en(layer_en), .layer_x(layer_x),
    .layer_y(layer_y), .layer_w(layer_w), .layer_h(layer_h), .layer_base(layer_base),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_out(pix_out), .pix_out_vld(pix_out_vld),
    .collision(collision)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Sprite ROM with one cycle of read latency
  logic [PW-1:0] rom_mem [NL][65536];
  always @(posedge clk_25MHz) begin
    for (int l = 0; l < NL; l++) rom_data[l*PW +: PW] <= rom_mem[l][rom_addr[l*AW +: AW]];
  end

  int sh_en [NL];
  int sh_x [NL];
  int sh_y [NL];
  int sh_w [NL];
  int sh_h [NL];
  int sh_base [NL];
  logic [NL-1:0] m_acc;
  logic [NL-1:0] m_coll;
  logic [PW-1:0] h_pix [HN];
  logic          h_vld [HN];
  logic [AW-1:0] h_addr [HN][NL];
  logic [NL-1:0] h_coll [HN];
  int cyc = 0;
  int hist_from = 0;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic set_layer(input int l, input bit en, input int x, input int y,
                           input int w, input int h, input int base);
    layer_en[l]             = en;
    layer_x[l*CW +: CW]     = CW'(x);
    layer_y[l*RW +: RW]     = RW'(y);
    layer_w[l*CW +: CW]     = CW'(w);
    layer_h[l*RW +: RW]     = RW'(h);
    layer_base[l*AW +: AW]  = AW'(base);
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      sh_en[l] = 0; sh_x[l] = 0; sh_y[l] = 0; sh_w[l] = 0; sh_h[l] = 0; sh_base[l] = 0;
    end
    m_acc  = 4'b0000;
    m_coll = 4'b0000;
  endtask

  // Drive one pixel, predict its results from the sprite rules, advance one clock
  task automatic step(input bit pv, input int r, input int c, input logic [PW-1:0] bg, input bit fs);
    int rx, ry, addr;
    bit hit, found;
    bit opq [NL];
    logic [PW-1:0] e;
    pix_valid = pv; row = RW'(r); col = CW'(c); bg_data = bg; frame_start = fs;
    if (fs) begin
      for (int l = 0; l < NL; l++) begin
        sh_en[l]   = int'(layer_en[l]);
        sh_x[l]    = int'(layer_x[l*CW +: CW]);
        sh_y[l]    = int'(layer_y[l*RW +: RW]);
        sh_w[l]    = int'(layer_w[l*CW +: CW]);
        sh_h[l]    = int'(layer_h[l*RW +: RW]);
        sh_base[l] = int'(layer_base[l*AW +: AW]);
      end
      m_coll = m_acc;
      m_acc  = 4'b0000;
    end
    e = pv ? bg : 12'h000;
    found = 1'b0;
    for (int l = 0; l < NL; l++) begin
      rx   = (c - sh_x[l] + 1024) % 1024;
      ry   = (r - sh_y[l] + 512) % 512;
      hit  = (sh_en[l] != 0) && pv && (rx < sh_w[l]) && (ry < sh_h[l]);
      addr = hit ? (sh_base[l] + ry * sh_w[l] + rx) % 65536 : 0;
      h_addr[cyc][l] = AW'(addr);
      opq[l] = hit && (rom_mem[l][addr] != 12'hFFF);
      if (opq[l] && !found) begin
        e = rom_mem[l][addr];
        found = 1'b1;
      end
    end
    for (int l = 1; l < NL; l++) if (opq[0] && opq[l]) m_acc[l] = 1'b1;
    h_pix[cyc]  = e;
    h_vld[cyc]  = pv;
    h_coll[cyc] = m_coll;
    @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    cyc++;
  endtask

  task automatic blanks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 12'h000, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pix_valid = 1'($urandom()); frame_start = 1'($urandom());
      row = RW'($urandom()); col = CW'($urandom()); bg_data = PW'($urandom());
      layer_en = NL'($urandom());
      layer_x = 40'({$urandom(), $urandom()}); layer_y = 36'({$urandom(), $urandom()});
      layer_w = 40'({$urandom(), $urandom()}); layer_h = 36'({$urandom(), $urandom()});
      layer_base = {$urandom(), $urandom()};
      @(posedge clk_25MHz); @(negedge clk_25MHz);
      n_cmp++; if (pix_out !== 12'h000) begin n_fail++; $display("FAIL reset_pix got=%h exp=000", pix_out); end
      n_cmp++; if (pix_out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", pix_out_vld); end
      n_cmp++; if (rom_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", rom_addr); end
      n_cmp++; if (collision !== 4'b0000) begin n_fail++; $display("FAIL reset_coll got=%b exp=0000", collision); end
    end
    frame_start = 1'b0; pix_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    hist_from = cyc;
  endtask

  task automatic test_single();
    set_layer(0, 1'b1, 100, 50, 34, 20, 0);
    for (int l = 1; l < NL; l++) set_layer(l, 1'b0, 0, 0, 0, 0, 0);
    rom_mem[0][69] = 12'h5A5;
    step(1'b1, 0, 0, 12'h00F, 1'b1);
    blanks(1);
    step(1'b1, 52, 101, 12'h321, 1'b0);
    n_cmp++; if (rom_addr[15:0] !== 16'd69) begin n_fail++; $display("FAIL single_addr got=%0d exp=69", rom_addr[15:0]); end
    n_cmp++; if (rom_addr[63:16] !== 48'h0) begin n_fail++; $display("FAIL single_other_addr got=%h exp=0", rom_addr[63:16]); end
    blanks(2);
    n_cmp++; if (pix_out !== 12'h5A5) begin n_fail++; $display("FAIL single_pix got=%h exp=5a5", pix_out); end
    n_cmp++; if (pix_out_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld got=%b exp=1", pix_out_vld); end
    blanks(1);
    n_cmp++; if (pix_out_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_off got=%b exp=0", pix_out_vld); end
    blanks(2);
  endtask

  task automatic test_priority();
    logic [PW-1:0] p0 [3];
    logic [PW-1:0] p1 [3];
    logic [PW-1:0] ex [3];
    p0[0] = 12'hFFF; p1[0] = 12'h0F0; ex[0] = 12'h0F0;
    p0[1] = 12'hF00; p1[1] = 12'h0F0; ex[1] = 12'hF00;
    p0[2] = 12'hFFF; p1[2] = 12'hFFF; ex[2] = 12'h00F;
    set_layer(0, 1'b1, 10, 10, 4, 4, 0);
    set_layer(1, 1'b1, 10, 10, 4, 4, 100);
    set_layer(2, 1'b0, 10, 10, 4, 4, 200);
    set_layer(3, 1'b0, 10, 10, 4, 4, 300);
    step(1'b1, 0, 0, 12'h00F, 1'b1);
    blanks(2);
    for (int k = 0; k < 3; k++) begin
      rom_mem[0][1] = p0[k];
      rom_mem[1][101] = p1[k];
      step(1'b1, 10, 11, 12'h00F, 1'b0);
      blanks(2);
      n_cmp++; if (pix_out !== ex[k]) begin n_fail++; $display("FAIL priority_%0d got=%h exp=%h", k, pix_out, ex[k]); end
    end
    blanks(2);
  endtask

  task automatic test_tearing();
    set_layer(0, 1'b1, 100, 0, 34, 20, 500);
    for (int l = 1; l < NL; l++) set_layer(l, 1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 12'h0AA, 1'b1);
    set_layer(0, 1'b1, 200, 0, 34, 20, 500);
    step(1'b1, 5, 105, 12'h0AA, 1'b0);
    n_cmp++; if (rom_addr[15:0] !== 16'd675) begin n_fail++; $display("FAIL tear_old_x got=%0d exp=675", rom_addr[15:0]); end
    step(1'b1, 5, 205, 12'h0AA, 1'b0);
    n_cmp++; if (rom_addr[15:0] !== 16'd0) begin n_fail++; $display("FAIL tear_new_x_early got=%0d exp=0", rom_addr[15:0]); end
    n_cmp++; if (cyc - 3 >= hist_from && pix_out !== h_pix[cyc-3]) begin n_fail++; $display("FAIL tear_pix got=%h exp=%h", pix_out, h_pix[cyc-3]); end
    blanks(2);
    step(1'b1, 5, 205, 12'h0AA, 1'b1);
    n_cmp++; if (rom_addr[15:0] !== 16'd675) begin n_fail++; $display("FAIL tear_fs_bypass got=%0d exp=675", rom_addr[15:0]); end
    blanks(2);
    n_cmp++; if (pix_out !== h_pix[cyc-3]) begin n_fail++; $display("FAIL tear_fs_pix got=%h exp=%h", pix_out, h_pix[cyc-3]); end
    blanks(2);
  endtask

  task automatic test_collision();
    set_layer(0, 1'b1, 20, 20, 8, 8, 0);
    set_layer(1, 1'b1, 100, 100, 8, 8, 1000);
    set_layer(2, 1'b1, 24, 24, 8, 8, 2000);
    set_layer(3, 1'b1, 104, 104, 8, 8, 3000);
    rom_mem[0][45] = 12'h123; rom_mem[2][2009] = 12'h456;
    rom_mem[1][1045] = 12'h111; rom_mem[3][3009] = 12'h222;
    step(1'b1, 0, 0, 12'h000, 1'b1);
    step(1'b1, 25, 25, 12'h000, 1'b0);
    step(1'b1, 105, 105, 12'h000, 1'b0);
    blanks(3);
    step(1'b1, 0, 0, 12'h000, 1'b1);
    n_cmp++; if (collision !== 4'b0100) begin n_fail++; $display("FAIL coll_set got=%b exp=0100", collision); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 105, 105 - k, 12'h000, 1'b0);
      n_cmp++; if (collision !== 4'b0100) begin n_fail++; $display("FAIL coll_hold_%0d got=%b exp=0100", k, collision); end
    end
    blanks(3);
    step(1'b1, 0, 0, 12'h000, 1'b1);
    n_cmp++; if (collision !== 4'b0000) begin n_fail++; $display("FAIL coll_clear got=%b exp=0000", collision); end
    blanks(2);
  endtask

  task automatic test_clip();
    logic [PW-1:0] bg;
    bg = 12'h7C3;
    set_layer(0, 1'b0, 0, 0, 0, 0, 0);
    set_layer(1, 1'b1, 630, 0, 34, 20, 0);
    set_layer(2, 1'b0, 0, 0, 0, 0, 0);
    set_layer(3, 1'b0, 0, 0, 34, 20, 0);
    rom_mem[1][111] = 12'h9E1;
    step(1'b1, 3, 0, bg, 1'b1);
    n_cmp++; if (rom_addr[31:16] !== 16'd0) begin n_fail++; $display("FAIL clip_addr1 got=%0d exp=0", rom_addr[31:16]); end
    n_cmp++; if (rom_addr[63:48] !== 16'd0) begin n_fail++; $display("FAIL disabled_addr3 got=%0d exp=0", rom_addr[63:48]); end
    step(1'b1, 3, 639, 12'h000, 1'b0);
    n_cmp++; if (rom_addr[31:16] !== 16'd111) begin n_fail++; $display("FAIL clip_edge_addr1 got=%0d exp=111", rom_addr[31:16]); end
    step(1'b0, 0, 0, 12'h000, 1'b0);
    n_cmp++; if (pix_out !== bg) begin n_fail++; $display("FAIL clip_pix got=%h exp=%h", pix_out, bg); end
    step(1'b0, 0, 0, 12'h000, 1'b0);
    n_cmp++; if (pix_out !== 12'h9E1) begin n_fail++; $display("FAIL clip_edge_pix got=%h exp=9e1", pix_out); end
    blanks(2);
  endtask

  task automatic rand_layers();
    for (int l = 0; l < NL; l++)
      set_layer(l, ($urandom_range(0, 4) != 0), $urandom_range(0, 50), $urandom_range(0, 50),
                $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 65535));
  endtask

  task automatic test_random();
    logic [NL*AW-1:0] ea;
    int r, c;
    for (int f = 0; f < 12; f++) begin
      rand_layers();
      for (int k = 0; k < 52; k++) begin
        if (k == 25) rand_layers();
        r = $urandom_range(0, 63);
        c = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 63);
        if (k >= 50) step(1'b0, r, c, PW'($urandom()), 1'b0);
        else step(($urandom_range(0, 4) != 0) || k == 0, r, c, PW'($urandom()), k == 0);
        for (int l = 0; l < NL; l++) ea[l*AW +: AW] = h_addr[cyc-1][l];
        n_cmp++; if (rom_addr !== ea) begin n_fail++; $display("FAIL rand_addr got=%h exp=%h", rom_addr, ea); end
        n_cmp++; if (collision !== h_coll[cyc-1]) begin n_fail++; $display("FAIL rand_coll got=%b exp=%b", collision, h_coll[cyc-1]); end
        if (cyc - 3 >= hist_from) begin
          n_cmp++; if (pix_out !== h_pix[cyc-3]) begin n_fail++; $display("FAIL rand_pix got=%h exp=%h", pix_out, h_pix[cyc-3]); end
          n_cmp++; if (pix_out_vld !== h_vld[cyc-3]) begin n_fail++; $display("FAIL rand_vld got=%b exp=%b", pix_out_vld, h_vld[cyc-3]); end
        end
      end
    end
    blanks(2);
  endtask

  task automatic test_reset_midframe();
    set_layer(0, 1'b1, 0, 0, 16, 16, 0);
    set_layer(1, 1'b1, 0, 0, 16, 16, 300);
    set_layer(2, 1'b0, 0, 0, 0, 0, 0);
    set_layer(3, 1'b0, 0, 0, 0, 0, 0);
    rom_mem[0][17] = 12'h0A0; rom_mem[1][317] = 12'h0B0;
    step(1'b1, 1, 1, 12'h000, 1'b1);
    blanks(3);
    step(1'b1, 0, 20, 12'h000, 1'b1);
    n_cmp++; if (collision !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_coll got=%b exp=0010", collision); end
    step(1'b1, 1, 1, 12'h000, 1'b0);
    step(1'b1, 1, 1, 12'h000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pix_out !== 12'h000) begin n_fail++; $display("FAIL midrst_pix got=%h exp=000", pix_out); end
    n_cmp++; if (pix_out_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld got=%b exp=0", pix_out_vld); end
    n_cmp++; if (rom_addr !== 64'h0) begin n_fail++; $display("FAIL midrst_addr got=%h exp=0", rom_addr); end
    n_cmp++; if (collision !== 4'b0000) begin n_fail++; $display("FAIL midrst_coll got=%b exp=0000", collision); end
    @(negedge clk_25MHz);
    pix_valid = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;
    model_reset();
    hist_from = cyc;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 0, 0, 12'h000, 1'b0);
      n_cmp++; if (pix_out_vld !== 1'b0 || pix_out !== 12'h000) begin n_fail++; $display("FAIL midrst_flush_%0d got=%b/%h exp=0/000", k, pix_out_vld, pix_out); end
    end
    n_cmp++; if (collision !== 4'b0000) begin n_fail++; $display("FAIL midrst_coll_after got=%b exp=0000", collision); end
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; row = '0; col = '0; bg_data = '0;
    layer_en = '0; layer_x = '0; layer_y = '0; layer_w = '0; layer_h = '0; layer_base = '0;
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 65536; a++)
        rom_mem[l][a] = ($urandom_range(0, 3) == 0) ? 12'hFFF : PW'($urandom());
    model_reset();
    @(negedge clk_25MHz);
    test_reset();
    test_single();
    test_priority();
    test_tearing();
    test_collision();
    test_clip();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
